cipher_selftest_seq: RTL and testbench
======================================

Name: cipher_selftest_seq

Overview:
Parametrised built-in self-test sequencer for the XOR-cipher / grammar-FSM chain. It encrypts a programmable plaintext pattern with a programmable repeating key and emits it over a valid/ready byte stream into xor_cipher. It then watches the grammar_fsm accept/reject verdict, scores each run against the expected outcome, and reports pass/fail counts and status for LEDs.
Unlike a fixed three-byte feeder, it adds arbitrary pattern and key lengths, backpressure, an error-injection mode, verdict timeout and scoring.

Parameters:
PAT_LEN, 3, plaintext pattern length in bytes (1..16)
PAT, 24'h434154, plaintext, PAT_LEN*8 bits; byte 0 = most significant byte ("CAT")
KEY_LEN, 3, key length in bytes (1..16)
KEY, 24'hDEADBE, key, KEY_LEN*8 bits; key byte 0 = most significant byte
BYTE_GAP, 0, idle cycles before each byte is offered (0 = back-to-back)
TIMEOUT, 1024, cycles allowed after the last byte handshake for a verdict
CNT_W, 8, width of the pass and fail counters

Ports:
CLK  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; starts a single run when idle
cont_mode  in  1  level; runs back-to-back while high
inject_err  in  1  level; enables corrupted runs
out_data  out  8  encrypted byte to the cipher
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the byte
fsm_accept  in  1  grammar FSM accept pulse
fsm_reject  in  1  grammar FSM reject pulse
busy  out  1  a run is in progress
done  out  1  one-cycle pulse when a run is scored
last_pass  out  1  most recent run matched its expectation
timeout_flag  out  1  most recent run timed out
pass_cnt  out  CNT_W  count of passed runs, saturating
fail_cnt  out  CNT_W  count of failed runs, saturating

Behaviour:
- Reset: rst_n low at a CLK edge sets every output and counter to 0 and the state to IDLE. This applies mid-run too: out_valid drops the next cycle and the partial run is not scored.
- States: IDLE, GAP, SEND, WAIT, SCORE.
- IDLE -> GAP on start=1 or cont_mode=1. Byte index i=0. The run latches its expectation: corrupt = inject_err, except in continuous mode with inject_err=1, where runs alternate clean, corrupt, clean, ... starting with clean.
- start while busy is ignored.
- GAP: counts BYTE_GAP cycles, then -> SEND. With BYTE_GAP=0 it passes straight through, so SEND is entered in the cycle after the IDLE exit.
- SEND: out_valid=1 with out_data = P[i] ^ K[i mod KEY_LEN].
  - P[i] is plaintext byte i. On a corrupt run, bit 0 of byte PAT_LEN-1 is inverted before encryption.
  - out_data and out_valid stay stable until out_valid & out_ready. Data never changes while valid is high and ready is low.
  - On a handshake: if i < PAT_LEN-1, i increments and the state -> GAP; otherwise -> WAIT.
- Verdict capture: from the first handshake onward, the first cycle with fsm_accept or fsm_reject high is latched and later pulses are ignored. A cycle with both high is latched as "conflict".
  - A verdict latched during SEND does not abort the run: all bytes are still sent, then WAIT exits immediately.
- WAIT: exits to SCORE when a verdict is latched, or after TIMEOUT cycles with none (timeout_flag=1).
- SCORE (one cycle): done=1.
  - pass = (clean run and accept) or (corrupt run and reject).
  - A conflict or a timeout is always a fail.
  - last_pass=pass; pass_cnt or fail_cnt increments and holds at 2^CNT_W-1.
  - Next state -> GAP (new run) if cont_mode=1, else -> IDLE.
- busy = 1 in every state except IDLE.
- Clearing cont_mode mid-run lets the current run finish and be scored.
- Key index wraps modulo KEY_LEN independently of PAT_LEN: KEY_LEN=2 with PAT_LEN=3 uses K0 K1 K0.
- Latency with BYTE_GAP=0 and out_ready tied high: first byte valid 1 cycle after start, one byte per cycle after that.

Decomposition:
- Shared package cipher_pkg: the state enum, the default CAT pattern and DEADBE key constants, and the 8-bit byte width constant. xor_cipher and top-level tests reuse it.
- One sub-module, cipher_byte_src: holds the pattern/key index registers and the wrap logic, and produces the (corrupted) encrypted byte for index i.
- The FSM and scoring stay in cipher_selftest_seq.

Test Plan:
- Defaults, out_ready=1, start pulse; the model answers with fsm_accept 2 cycles after the 3rd byte -> bytes 9D, EC, EA on consecutive cycles; done, last_pass=1, pass_cnt=1.
- inject_err=1, start -> bytes 9D, EC, EB. An fsm_reject response gives last_pass=1. An fsm_accept response instead gives fail_cnt=1.
- out_ready low for 5 cycles on byte 1 -> out_data held at EC with out_valid=1 throughout; the sequence completes normally once ready rises.
- No verdict after the last byte -> done exactly TIMEOUT cycles later, timeout_flag=1, fail_cnt=1. Separately, fsm_accept and fsm_reject high in the same cycle -> fail.
- cont_mode=1, inject_err=1 for 4 runs with a correct model -> expectations clean, corrupt, clean, corrupt; pass_cnt=4. With CNT_W=2 and 5 passing runs, pass_cnt saturates at 3.
- rst_n low during byte 1 -> next cycle out_valid=0, busy=0, counters 0; a new start resends from 9D.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and constants for the XOR-cipher self-test chain.
package cipher_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [23:0] DEF_PAT = 24'h434154;
    localparam logic [23:0] DEF_KEY = 24'hDEADBE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_SEND,
        ST_WAIT,
        ST_SCORE
    } state_t;

endpackage

// File: rtl/cipher_byte_src.sv
// Pattern/key index tracking and encrypted byte generation.
module cipher_byte_src
    import cipher_pkg::*;
#(
    parameter int unsigned                  PAT_LEN = 3,
    parameter logic [PAT_LEN*BYTE_W-1:0]    PAT     = DEF_PAT,
    parameter int unsigned                  KEY_LEN = 3,
    parameter logic [KEY_LEN*BYTE_W-1:0]    KEY     = DEF_KEY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              advance,
    input  logic              corrupt,
    output logic [BYTE_W-1:0] data,
    output logic              last
);

    localparam logic [IDX_W-1:0] P_LAST = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(KEY_LEN - 1);

    logic [IDX_W-1:0]  pidx;
    logic [IDX_W-1:0]  kidx;
    logic [BYTE_W-1:0] pbyte;
    logic [BYTE_W-1:0] kbyte;

    // Byte and key indices; the key index wraps on its own length.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            pidx <= '0;
            kidx <= '0;
        end else if (advance) begin
            pidx <= pidx + 1'b1;
            kidx <= (kidx == K_LAST) ? '0 : kidx + 1'b1;
        end
    end

    // Select plaintext/key bytes (byte 0 is the MSB) and encrypt.
    always_comb begin
        pbyte = '0;
        kbyte = '0;
        for (int unsigned n = 0; n < PAT_LEN; n++) begin
            if (pidx == IDX_W'(n)) pbyte = PAT[(PAT_LEN-1-n)*BYTE_W +: BYTE_W];
        end
        for (int unsigned n = 0; n < KEY_LEN; n++) begin
            if (kidx == IDX_W'(n)) kbyte = KEY[(KEY_LEN-1-n)*BYTE_W +: BYTE_W];
        end
        last = (pidx == P_LAST);
        if (corrupt && last) pbyte[0] = ~pbyte[0];
        data = pbyte ^ kbyte;
    end

endmodule

// File: rtl/cipher_selftest_seq.sv
// Built-in self-test sequencer: streams an encrypted pattern, scores the
// grammar FSM verdict and keeps saturating pass/fail counts.
module cipher_selftest_seq
    import cipher_pkg::*;
#(
    parameter int unsigned                  PAT_LEN  = 3,
    parameter logic [PAT_LEN*BYTE_W-1:0]    PAT      = DEF_PAT,
    parameter int unsigned                  KEY_LEN  = 3,
    parameter logic [KEY_LEN*BYTE_W-1:0]    KEY      = DEF_KEY,
    parameter int unsigned                  BYTE_GAP = 0,
    parameter int unsigned                  TIMEOUT  = 1024,
    parameter int unsigned                  CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             inject_err,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             fsm_accept,
    input  logic             fsm_reject,
    output logic             busy,
    output logic             done,
    output logic             last_pass,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    // With no gap the GAP state is skipped entirely so bytes go back-to-back.
    localparam state_t      ENTRY    = (BYTE_GAP == 0) ? ST_SEND : ST_GAP;
    localparam logic [31:0] GAP_LAST = (BYTE_GAP == 0) ? 32'd0 : 32'(BYTE_GAP - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] gap_cnt;
    logic [31:0] wait_cnt;
    logic        corrupt;
    logic        alt;
    logic        armed;
    logic        latched;
    logic        lat_acc;
    logic        lat_rej;
    logic        hs;
    logic        run_start;
    logic        cap_now;
    logic        v_acc;
    logic        v_rej;
    logic        to_score;
    logic        timed_out;
    logic        pass_now;
    logic        byte_last;
    logic [7:0]  src_data;

    cipher_byte_src #(
        .PAT_LEN (PAT_LEN),
        .PAT     (PAT),
        .KEY_LEN (KEY_LEN),
        .KEY     (KEY)
    ) u_src (
        .clk     (CLK),
        .rst_n   (rst_n),
        .restart (run_start),
        .advance (hs && !byte_last),
        .corrupt (corrupt),
        .data    (src_data),
        .last    (byte_last)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state, outputs and verdict/scoring decode.
    always_comb begin
        state_nx  = state;
        run_start = 1'b0;
        to_score  = 1'b0;
        timed_out = 1'b0;
        out_valid = (state == ST_SEND);
        out_data  = out_valid ? src_data : '0;
        busy      = (state != ST_IDLE);
        done      = (state == ST_SCORE);
        hs        = out_valid && out_ready;
        cap_now   = (state == ST_GAP || state == ST_SEND || state == ST_WAIT) &&
                    (armed || hs) && !latched && (fsm_accept || fsm_reject);
        // A verdict arriving this cycle is scored without waiting for the latch.
        v_acc     = latched ? lat_acc : fsm_accept;
        v_rej     = latched ? lat_rej : fsm_reject;
        case (state)
            ST_IDLE: begin
                if (start || cont_mode) begin
                    state_nx  = ENTRY;
                    run_start = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = ST_SEND;
            end
            ST_SEND: begin
                if (hs) state_nx = byte_last ? ST_WAIT : ENTRY;
            end
            ST_WAIT: begin
                if (latched || cap_now) begin
                    to_score = 1'b1;
                end else if (wait_cnt == TO_LAST) begin
                    to_score  = 1'b1;
                    timed_out = 1'b1;
                end
                if (to_score) state_nx = ST_SCORE;
            end
            ST_SCORE: begin
                if (cont_mode) begin
                    state_nx  = ENTRY;
                    run_start = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        pass_now = !timed_out && !(v_acc && v_rej) && (corrupt ? v_rej : v_acc);
    end

    // Run bookkeeping: gap/wait timers, run expectation and verdict latch.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            gap_cnt  <= '0;
            wait_cnt <= '0;
            corrupt  <= 1'b0;
            alt      <= 1'b0;
            armed    <= 1'b0;
            latched  <= 1'b0;
            lat_acc  <= 1'b0;
            lat_rej  <= 1'b0;
        end else begin
            gap_cnt  <= (state == ST_GAP)  ? gap_cnt + 32'd1  : '0;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 32'd1 : '0;
            if (run_start) begin
                // First run from idle is clean in continuous mode; later runs alternate.
                corrupt <= (state == ST_IDLE) ? (inject_err && !cont_mode) : (inject_err && alt);
                alt     <= (state == ST_IDLE) ? 1'b1 : !alt;
                armed   <= 1'b0;
                latched <= 1'b0;
                lat_acc <= 1'b0;
                lat_rej <= 1'b0;
            end else begin
                if (hs) armed <= 1'b1;
                if (cap_now) begin
                    latched <= 1'b1;
                    lat_acc <= fsm_accept;
                    lat_rej <= fsm_reject;
                end
            end
        end
    end

    // Score result and saturating counters, visible during the done cycle.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            last_pass    <= 1'b0;
            timeout_flag <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else if (to_score) begin
            last_pass    <= pass_now;
            timeout_flag <= timed_out;
            if (pass_now) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cipher_selftest_seq.sv
// Self-checking bench for cipher_selftest_seq: default instance plus a
// narrow-counter, two-byte-key, gapped instance selected by sel.
module tb_cipher_selftest_seq;

    localparam int T1 = 1024;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_n = 1'b0, start = 1'b0, cont_mode = 1'b0, inject_err = 1'b0;
    logic out_ready = 1'b1, fsm_accept = 1'b0, fsm_reject = 1'b0, sel = 1'b0;

    logic [7:0] d1_data, d2_data;
    logic       d1_valid, d1_busy, d1_done, d1_lp, d1_tf;
    logic       d2_valid, d2_busy, d2_done, d2_lp, d2_tf;
    logic [7:0] d1_pc, d1_fc;
    logic [1:0] d2_pc, d2_fc;

    cipher_selftest_seq #(.TIMEOUT(T1)) u_dut (
        .CLK(CLK), .rst_n(rst_n), .start(start && !sel), .cont_mode(cont_mode && !sel),
        .inject_err(inject_err), .out_data(d1_data), .out_valid(d1_valid),
        .out_ready(out_ready), .fsm_accept(fsm_accept), .fsm_reject(fsm_reject),
        .busy(d1_busy), .done(d1_done), .last_pass(d1_lp), .timeout_flag(d1_tf),
        .pass_cnt(d1_pc), .fail_cnt(d1_fc)
    );

    cipher_selftest_seq #(
        .PAT_LEN(3), .PAT(24'h434154), .KEY_LEN(2), .KEY(16'hA55A),
        .BYTE_GAP(2), .TIMEOUT(16), .CNT_W(2)
    ) u_dut2 (
        .CLK(CLK), .rst_n(rst_n), .start(start && sel), .cont_mode(cont_mode && sel),
        .inject_err(inject_err), .out_data(d2_data), .out_valid(d2_valid),
        .out_ready(out_ready), .fsm_accept(fsm_accept), .fsm_reject(fsm_reject),
        .busy(d2_busy), .done(d2_done), .last_pass(d2_lp), .timeout_flag(d2_tf),
        .pass_cnt(d2_pc), .fail_cnt(d2_fc)
    );

    logic [7:0] o_data;
    logic       o_valid, o_busy, o_done, o_lp, o_tf;
    int         o_pc, o_fc;
    always_comb begin
        o_data  = sel ? d2_data  : d1_data;
        o_valid = sel ? d2_valid : d1_valid;
        o_busy  = sel ? d2_busy  : d1_busy;
        o_done  = sel ? d2_done  : d1_done;
        o_lp    = sel ? d2_lp    : d1_lp;
        o_tf    = sel ? d2_tf    : d1_tf;
        o_pc    = sel ? int'(d2_pc) : int'(d1_pc);
        o_fc    = sel ? int'(d2_fc) : int'(d1_fc);
    end

    int checks = 0;
    int errors = 0;
    int exp_pass = 0;
    int exp_fail = 0;

    logic [7:0] r_bytes[$];
    int         r_hs_it[$];
    int         r_first_valid, r_done_k, r_hold_err;
    bit         r_got_done;

    // Plaintext "CAT", key DEADBE (sel=0) or A55A (sel=1), key index i mod length.
    function automatic logic [7:0] model_byte(input bit s, input int i, input bit corrupt);
        logic [7:0] p, k;
        case (i)
            0:       p = 8'h43;
            1:       p = 8'h41;
            default: p = 8'h54;
        endcase
        if (s) k = (i % 2 == 0) ? 8'hA5 : 8'h5A;
        else case (i % 3)
            0:       k = 8'hDE;
            1:       k = 8'hAD;
            default: k = 8'hBE;
        endcase
        if (corrupt && i == 2) p[0] = ~p[0];
        return p ^ k;
    endfunction

    function automatic bit model_pass(input bit corrupt, input bit acc, input bit rej, input bit timed);
        if (timed || (acc && rej)) return 1'b0;
        return corrupt ? rej : acc;
    endfunction

    task automatic bump(input bit pass);
        int cmax;
        cmax = sel ? 3 : 255;
        if (pass) exp_pass = (exp_pass < cmax) ? exp_pass + 1 : cmax;
        else      exp_fail = (exp_fail < cmax) ? exp_fail + 1 : cmax;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; fsm_accept = 1'b0; fsm_reject = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        exp_pass = 0;
        exp_fail = 0;
    endtask

    // Drives one run and records what the DUT produced; resp: 0 accept, 1 reject, 2 none, 3 both.
    task automatic run_once(input bit start_it, input int resp, input int delay, input int stall_byte,
                            input int stall_len, input bit rand_ready, input bit drop_cont);
        int  k, stalled;
        bit  seen_last, prev_v, prev_r;
        logic [7:0] prev_d;
        r_bytes.delete();
        r_hs_it.delete();
        r_first_valid = -1; r_done_k = -1; r_hold_err = 0; r_got_done = 1'b0;
        k = -1; stalled = 0; seen_last = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        if (start_it) begin
            @(negedge CLK);
            start = 1'b1;
        end
        for (int it = 1; it <= 4000; it++) begin
            @(negedge CLK);
            start = 1'b0; fsm_accept = 1'b0; fsm_reject = 1'b0;
            if (seen_last) k++;
            if (prev_v && !prev_r && (!o_valid || o_data !== prev_d)) r_hold_err++;
            if (o_done) begin
                r_got_done = 1'b1;
                r_done_k = k;
                break;
            end
            if (o_valid && r_first_valid < 0) r_first_valid = it;
            if (o_valid && int'(r_bytes.size()) == stall_byte && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            else out_ready = 1'b1;
            if (o_valid && out_ready) begin
                r_bytes.push_back(o_data);
                r_hs_it.push_back(it);
                if (r_bytes.size() == 1 && drop_cont) cont_mode = 1'b0;
                if (r_bytes.size() == 3) begin
                    seen_last = 1'b1;
                    k = -1;
                end
            end
            if (seen_last && k == delay) begin
                fsm_accept = (resp == 0 || resp == 3);
                fsm_reject = (resp == 1 || resp == 3);
            end
            prev_v = o_valid; prev_r = out_ready; prev_d = o_data;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", o_done); end
        checks++; if (o_lp !== 1'b0 || o_tf !== 1'b0) begin errors++; $display("FAIL reset_status got lp=%0b tf=%0b exp 0 0", o_lp, o_tf); end
        checks++; if (o_pc !== 0 || o_fc !== 0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", o_pc, o_fc); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 0", o_data); end
        checks++; if (d2_busy !== 1'b0 || d2_pc !== 2'd0) begin errors++; $display("FAIL reset_dut2 got busy=%0b pc=%0d exp 0 0", d2_busy, d2_pc); end
    endtask

    task automatic test_clean_run();
        inject_err = 1'b0;
        run_once(1'b1, 0, 2, -1, 0, 1'b0, 1'b0);
        bump(1'b1);
        checks++; if (r_got_done !== 1'b1 || r_bytes.size() != 3) begin errors++; $display("FAIL clean_done got done=%0b n=%0d exp 1 3", r_got_done, r_bytes.size()); end
        for (int i = 0; i < int'(r_bytes.size()); i++) begin
            checks++; if (r_bytes[i] !== model_byte(1'b0, i, 1'b0)) begin errors++; $display("FAIL clean_byte%0d got %0h exp %0h", i, r_bytes[i], model_byte(1'b0, i, 1'b0)); end
        end
        checks++; if (r_first_valid !== 1) begin errors++; $display("FAIL clean_latency got %0d exp 1", r_first_valid); end
        if (r_hs_it.size() == 3) begin
            checks++; if (r_hs_it[2] - r_hs_it[0] !== 2) begin errors++; $display("FAIL clean_b2b got %0d exp 2", r_hs_it[2] - r_hs_it[0]); end
        end
        checks++; if (r_done_k !== 3) begin errors++; $display("FAIL clean_done_lat got %0d exp 3", r_done_k); end
        checks++; if (o_lp !== 1'b1 || o_tf !== 1'b0) begin errors++; $display("FAIL clean_status got lp=%0b tf=%0b exp 1 0", o_lp, o_tf); end
        checks++; if (o_pc !== exp_pass || o_fc !== exp_fail) begin errors++; $display("FAIL clean_cnt got %0d/%0d exp %0d/%0d", o_pc, o_fc, exp_pass, exp_fail); end
    endtask

    task automatic test_inject();
        inject_err = 1'b1;
        run_once(1'b1, 1, 1, -1, 0, 1'b0, 1'b0);
        bump(1'b1);
        checks++; if (r_bytes.size() != 3 || r_bytes[2] !== 8'hEB) begin errors++; $display("FAIL inject_byte2 got n=%0d exp EB", r_bytes.size()); end
        checks++; if (o_lp !== 1'b1 || o_pc !== exp_pass) begin errors++; $display("FAIL inject_reject got lp=%0b pc=%0d exp 1 %0d", o_lp, o_pc, exp_pass); end
        run_once(1'b1, 0, 1, -1, 0, 1'b0, 1'b0);
        bump(1'b0);
        checks++; if (o_lp !== 1'b0 || o_fc !== exp_fail) begin errors++; $display("FAIL inject_accept got lp=%0b fc=%0d exp 0 %0d", o_lp, o_fc, exp_fail); end
        inject_err = 1'b0;
    endtask

    task automatic test_backpressure();
        run_once(1'b1, 0, 0, 1, 5, 1'b0, 1'b0);
        bump(1'b1);
        checks++; if (r_hold_err !== 0) begin errors++; $display("FAIL bp_hold got %0d exp 0", r_hold_err); end
        checks++; if (r_hs_it.size() != 3 || r_hs_it[1] - r_hs_it[0] !== 6) begin errors++; $display("FAIL bp_stall got n=%0d exp 3 with gap 6", r_hs_it.size()); end
        checks++; if (r_bytes.size() != 3 || r_bytes[1] !== 8'hEC || r_bytes[2] !== 8'hEA) begin errors++; $display("FAIL bp_bytes got n=%0d exp EC EA", r_bytes.size()); end
        checks++; if (o_lp !== 1'b1 || o_pc !== exp_pass) begin errors++; $display("FAIL bp_score got lp=%0b pc=%0d exp 1 %0d", o_lp, o_pc, exp_pass); end
    endtask

    task automatic test_timeout();
        run_once(1'b1, 2, 0, -1, 0, 1'b0, 1'b0);
        bump(1'b0);
        checks++; if (r_done_k !== T1) begin errors++; $display("FAIL timeout_lat got %0d exp %0d", r_done_k, T1); end
        checks++; if (o_tf !== 1'b1 || o_lp !== 1'b0) begin errors++; $display("FAIL timeout_flag got tf=%0b lp=%0b exp 1 0", o_tf, o_lp); end
        checks++; if (o_fc !== exp_fail) begin errors++; $display("FAIL timeout_cnt got %0d exp %0d", o_fc, exp_fail); end
    endtask

    task automatic test_conflict();
        run_once(1'b1, 3, 1, -1, 0, 1'b0, 1'b0);
        bump(1'b0);
        checks++; if (o_lp !== 1'b0 || o_tf !== 1'b0 || o_fc !== exp_fail) begin errors++; $display("FAIL conflict got lp=%0b tf=%0b fc=%0d exp 0 0 %0d", o_lp, o_tf, o_fc, exp_fail); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            bit cor, acc, rej, ok;
            int resp, pick;
            cor = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 3));
            resp = (pick == 2) ? 3 : (pick == 3 ? 0 : pick);
            inject_err = cor;
            run_once(1'b1, resp, int'($urandom_range(0, 6)), -1, 0, 1'b1, 1'b0);
            acc = (resp == 0 || resp == 3);
            rej = (resp == 1 || resp == 3);
            ok = model_pass(cor, acc, rej, 1'b0);
            bump(ok);
            checks++; if (r_bytes.size() != 3) begin errors++; $display("FAIL rand%0d_count got %0d exp 3", r, r_bytes.size()); end
            for (int i = 0; i < int'(r_bytes.size()); i++) begin
                checks++; if (r_bytes[i] !== model_byte(1'b0, i, cor)) begin errors++; $display("FAIL rand%0d_byte%0d got %0h exp %0h", r, i, r_bytes[i], model_byte(1'b0, i, cor)); end
            end
            checks++; if (r_hold_err !== 0) begin errors++; $display("FAIL rand%0d_hold got %0d exp 0", r, r_hold_err); end
            checks++; if (o_lp !== ok) begin errors++; $display("FAIL rand%0d_pass got %0b exp %0b", r, o_lp, ok); end
            checks++; if (o_pc !== exp_pass || o_fc !== exp_fail) begin errors++; $display("FAIL rand%0d_cnt got %0d/%0d exp %0d/%0d", r, o_pc, o_fc, exp_pass, exp_fail); end
        end
        inject_err = 1'b0;
    endtask

    task automatic test_cont_alternate();
        do_reset();
        cont_mode = 1'b1;
        inject_err = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bit cor;
            cor = (r % 2 == 1);
            run_once(1'b0, cor ? 1 : 0, 1, -1, 0, 1'b0, r == 3);
            bump(1'b1);
            checks++; if (r_bytes.size() != 3 || r_bytes[2] !== model_byte(1'b0, 2, cor)) begin errors++; $display("FAIL cont%0d_byte2 got n=%0d exp %0h", r, r_bytes.size(), model_byte(1'b0, 2, cor)); end
            checks++; if (o_lp !== 1'b1) begin errors++; $display("FAIL cont%0d_pass got %0b exp 1", r, o_lp); end
        end
        checks++; if (o_pc !== 4 || o_fc !== 0) begin errors++; $display("FAIL cont_cnt got %0d/%0d exp 4/0", o_pc, o_fc); end
        @(negedge CLK);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cont_stop got busy=%0b exp 0", o_busy); end
        inject_err = 1'b0;
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b1;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++; if (o_data !== 8'h9D) begin errors++; $display("FAIL mid_byte0 got %0h exp 9D", o_data); end
        @(negedge CLK);
        checks++; if (o_valid !== 1'b1 || o_data !== 8'hEC) begin errors++; $display("FAIL mid_byte1 got v=%0b %0h exp 1 EC", o_valid, o_data); end
        rst_n = 1'b0;
        @(negedge CLK);
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL mid_reset got v=%0b busy=%0b exp 0 0", o_valid, o_busy); end
        checks++; if (o_pc !== 0 || o_fc !== 0) begin errors++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", o_pc, o_fc); end
        rst_n = 1'b1;
        exp_pass = 0;
        exp_fail = 0;
        run_once(1'b1, 0, 0, -1, 0, 1'b0, 1'b0);
        bump(1'b1);
        checks++; if (r_bytes.size() != 3 || r_bytes[0] !== 8'h9D) begin errors++; $display("FAIL mid_restart got n=%0d exp 9D first", r_bytes.size()); end
        checks++; if (o_pc !== exp_pass) begin errors++; $display("FAIL mid_score got %0d exp %0d", o_pc, exp_pass); end
    endtask

    task automatic test_saturate();
        sel = 1'b1;
        do_reset();
        cont_mode = 1'b1;
        inject_err = 1'b0;
        for (int r = 0; r < 5; r++) begin
            run_once(1'b0, 0, 0, -1, 0, 1'b0, r == 4);
            bump(1'b1);
            checks++; if (r_bytes.size() != 3) begin errors++; $display("FAIL sat%0d_count got %0d exp 3", r, r_bytes.size()); end
            for (int i = 0; i < int'(r_bytes.size()); i++) begin
                checks++; if (r_bytes[i] !== model_byte(1'b1, i, 1'b0)) begin errors++; $display("FAIL sat%0d_byte%0d got %0h exp %0h", r, i, r_bytes[i], model_byte(1'b1, i, 1'b0)); end
            end
            if (r_hs_it.size() == 3) begin
                checks++; if (r_hs_it[1] - r_hs_it[0] !== 3) begin errors++; $display("FAIL sat%0d_gap got %0d exp 3", r, r_hs_it[1] - r_hs_it[0]); end
            end
            if (r == 0) begin
                checks++; if (r_first_valid !== 3) begin errors++; $display("FAIL sat_latency got %0d exp 3", r_first_valid); end
            end
            checks++; if (o_pc !== exp_pass) begin errors++; $display("FAIL sat%0d_cnt got %0d exp %0d", r, o_pc, exp_pass); end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_inject();
        test_backpressure();
        test_timeout();
        test_conflict();
        test_random();
        test_cont_alternate();
        test_reset_midrun();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end

endmodule
